interlock_ctrl: RTL and testbench
=================================

# interlock_ctrl

Issue-interlock controller for the dual-issue decode stage. It keeps a per-register busy scoreboard and a busy counter for the shared unpipelined FP divider. From these it drives the `interlock` input of decode, so that an upper/lower instruction pair is held until every source operand it reads is available and its divider use can be granted. It sits beside decode. It reads the pair's register fields and latency classes combinationally and updates its state on each issued pair.

## Interface
Parameters:
- `NREG`, 32: number of architectural GPRs tracked.
- `LAT_W`, 4: width of per-register busy counters and latency inputs.
- `FDIV_LAT`, 12: cycles the divider stays busy after an Fdiv issues.
- `CNT_W`, 32: width of the stall performance counter.

Ports:
- `clk` in 1: clock. One clock.
- `rst` in 1: reset, synchronous, active-high.
- `issue_valid` in 1: decode holds a valid pair this cycle.
- `flush` in 1: decode is squashing its pair (branch taken). The pair never issues.
- `u_src_use` in 3: upper source-used mask {s,b,a}.
- `u_ra` in 5, `u_rb` in 5, `u_rs` in 5: upper source register numbers.
- `u_dst_we` in 1: upper writes `u_dst`.
- `u_dst` in 5: upper destination register number.
- `u_lat` in LAT_W: upper result latency.
- `u_fdiv` in 1: upper is an Fdiv.
- `l_src_use` in 3, `l_ra` in 5, `l_rb` in 5, `l_rs` in 5, `l_dst_we` in 1, `l_dst` in 5, `l_lat` in LAT_W, `l_fdiv` in 1: same fields for the lower slot.
- `interlock` out 1: hold decode this cycle. Combinational.
- `issue` out 1: pair issues this cycle. Equals `issue_valid & ~flush & ~interlock`.
- `stall_cnt` out CNT_W: interlocked-cycle count, saturating.
- `err` out 1: sticky flag for an illegal pair (both slots Fdiv).

## Operation
State:
- `busy[0..NREG-1]`: LAT_W-bit counters.
- `div_busy`: counts down from FDIV_LAT, sized to hold FDIV_LAT.
- `stall_cnt`, `err`.
- Register 0 is tracked like any other register.

Hazard terms. All hazard terms are masked by `issue_valid & ~flush`; with that mask low, `interlock` = 0.
- RAW: any used source register r of either slot has `busy[r] != 0`.
- WAW: any slot with `dst_we` has `busy[dst] != 0`.
- Structural: (`u_fdiv | l_fdiv`) and `div_busy != 0`.
- `interlock` = RAW | WAW | structural.
- Intra-pair dependencies (lower reads upper's destination) are the compiler's responsibility and are not checked.

Every cycle, with no exception, every nonzero `busy[r]` and `div_busy` decrement by 1.

On `issue`:
- For each slot with `dst_we` and `lat != 0`, `busy[dst]` <= `lat`. The newly loaded value overrides that register's decrement in the same cycle.
- If both slots load the same register, the lower slot's `lat` wins.
- `lat` = 0 creates no entry.
- If either Fdiv bit is set, `div_busy` <= FDIV_LAT.

`stall_cnt` increments when `issue_valid & ~flush & interlock`. It holds at all-ones.

`err` is set when `issue_valid & u_fdiv & l_fdiv`. It clears only on `rst`. The pair still follows the normal rules; on issue it loads `div_busy` once.

## Timing
Reset (`rst` high at an edge): all `busy` = 0, `div_busy` = 0, `stall_cnt` = 0, `err` = 0. Consequently `interlock` = 0 the cycle after reset. Reset mid-countdown discards all pending entries.

Latency semantics: pair P issues at cycle t with `dst_we`, `dst` = r, `lat` = L ≥ 1.
- Counter value: `busy[r]` = L at t+1, and reaches 0 at t+1+L.
- A pair reading r presented from t+1 onward is interlocked at cycles t+1 … t+L. It issues at t+L+1, i.e. L stall cycles.

Divider: an Fdiv issuing at t blocks Fdiv pairs through t+FDIV_LAT. The next Fdiv issues no earlier than t+FDIV_LAT+1.

`flush` has priority: with `flush` = 1, `interlock` = 0 and `issue` = 0 whatever the hazards. Counters keep decrementing.

There is no handshake beyond `interlock`. Decode holds its inputs stable while `interlock` = 1.

## Test plan
- **Load-use stall.** Reset; issue pair with `u_dst_we`, `u_dst` = 5, `u_lat` = 2; next pair uses `l_ra` = 5 → `interlock` = 1 for exactly 2 cycles, `issue` on the 3rd; `stall_cnt` = 2.
- **Divider contention.** Issue `u_fdiv` at t; next pair has `l_fdiv`, other registers free → `interlock` high through t+12, issue at t+13; `stall_cnt` = 12.
- **Flush priority.** Set `busy[7]` = 3; present a pair reading r7 with `flush` = 1 → `interlock` = 0, `issue` = 0, `stall_cnt` unchanged, `busy[7]` = 2 next cycle.
- **Same-destination pair.** Issue a pair with `u_dst` = `l_dst` = 9, `u_lat` = 1, `l_lat` = 4 → a reader of r9 stalls 4 cycles. Also issue `u_lat` = 0 alone → no stall.
- **Reset mid-operation and error.** With `busy[3]` = 4 and `div_busy` = 6, assert `rst` one cycle → a pair reading r3 with Fdiv issues immediately. Present `u_fdiv` = `l_fdiv` = 1 → `err` = 1, sticky until `rst`.
- **WAW and counter saturation.** `busy[2]` = 2; pair writing r2 without reading it → interlock 2 cycles. Preload `stall_cnt` near all-ones via a long stall → holds at all-ones.

Source files
------------

// File: rtl/interlock_ctrl_if.sv
// Decode-side bundle for the issue interlock: the pair's register fields,
// latency classes and divider use flow in; interlock/issue flow back.
// Handshake: there is none beyond interlock. Decode presents a pair with
// issue_valid, holds every field stable while interlock is high, and the
// pair is consumed in the cycle issue is high (issue_valid & ~flush & ~interlock).
interface interlock_ctrl_if #(
   parameter int LAT_W = 4
);
   logic             issue_valid;
   logic             flush;
   logic [2:0]       u_src_use;
   logic [4:0]       u_ra;
   logic [4:0]       u_rb;
   logic [4:0]       u_rs;
   logic             u_dst_we;
   logic [4:0]       u_dst;
   logic [LAT_W-1:0] u_lat;
   logic             u_fdiv;
   logic [2:0]       l_src_use;
   logic [4:0]       l_ra;
   logic [4:0]       l_rb;
   logic [4:0]       l_rs;
   logic             l_dst_we;
   logic [4:0]       l_dst;
   logic [LAT_W-1:0] l_lat;
   logic             l_fdiv;
   logic             interlock;
   logic             issue;

   modport master (
      output issue_valid, flush,
      output u_src_use, u_ra, u_rb, u_rs, u_dst_we, u_dst, u_lat, u_fdiv,
      output l_src_use, l_ra, l_rb, l_rs, l_dst_we, l_dst, l_lat, l_fdiv,
      input  interlock, issue
   );

   modport slave (
      input  issue_valid, flush,
      input  u_src_use, u_ra, u_rb, u_rs, u_dst_we, u_dst, u_lat, u_fdiv,
      input  l_src_use, l_ra, l_rb, l_rs, l_dst_we, l_dst, l_lat, l_fdiv,
      output interlock, issue
   );
endinterface

// File: rtl/interlock_ctrl.sv
// Issue-interlock controller for the dual-issue decode stage. Tracks a
// per-register busy countdown and a divider busy countdown, and holds the
// decode pair until its sources, destinations and divider use are all free.
module interlock_ctrl #(
   parameter int NREG     = 32,
   parameter int LAT_W    = 4,
   parameter int FDIV_LAT = 12,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   interlock_ctrl_if.slave  bus,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             err
);

   localparam int DIV_W = $clog2(FDIV_LAT + 1);

   logic [LAT_W-1:0] busy [NREG];
   logic [NREG-1:0]  busy_nz;
   logic [DIV_W-1:0] div_busy;

   logic req;
   logic raw_haz;
   logic waw_haz;
   logic div_haz;
   logic interlock_w;
   logic issue_w;

   // Flatten the busy counters into a one-bit "still pending" view per register.
   always_comb begin
      busy_nz = '0;
      for (int i = 0; i < NREG; i++) begin
         busy_nz[i] = (busy[i] != '0);
      end
   end

   // Hazard evaluation; flush and an empty slot mask every term.
   always_comb begin
      req     = bus.issue_valid & ~bus.flush;
      raw_haz = (bus.u_src_use[0] & busy_nz[bus.u_ra]) |
                (bus.u_src_use[1] & busy_nz[bus.u_rb]) |
                (bus.u_src_use[2] & busy_nz[bus.u_rs]) |
                (bus.l_src_use[0] & busy_nz[bus.l_ra]) |
                (bus.l_src_use[1] & busy_nz[bus.l_rb]) |
                (bus.l_src_use[2] & busy_nz[bus.l_rs]);
      waw_haz = (bus.u_dst_we & busy_nz[bus.u_dst]) |
                (bus.l_dst_we & busy_nz[bus.l_dst]);
      div_haz = (bus.u_fdiv | bus.l_fdiv) & (div_busy != '0);
      interlock_w = req & (raw_haz | waw_haz | div_haz);
      issue_w     = req & ~(raw_haz | waw_haz | div_haz);
   end

   assign bus.interlock = interlock_w;
   assign bus.issue     = issue_w;

   // Busy countdown per register; a fresh load beats the decrement, lower slot beats upper.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (rst) begin
            busy[i] <= '0;
         end else if (issue_w && bus.l_dst_we && bus.l_lat != '0 && bus.l_dst == 5'(i)) begin
            busy[i] <= bus.l_lat;
         end else if (issue_w && bus.u_dst_we && bus.u_lat != '0 && bus.u_dst == 5'(i)) begin
            busy[i] <= bus.u_lat;
         end else if (busy[i] != '0) begin
            busy[i] <= busy[i] - LAT_W'(1);
         end
      end
   end

   // Divider occupancy; a pair with both Fdiv bits still loads it only once.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_busy <= '0;
      end else if (issue_w && (bus.u_fdiv || bus.l_fdiv)) begin
         div_busy <= DIV_W'(FDIV_LAT);
      end else if (div_busy != '0) begin
         div_busy <= div_busy - DIV_W'(1);
      end
   end

   // Saturating count of cycles a live pair was held.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (interlock_w && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   // Sticky flag for a pair that asks for the divider in both slots.
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (bus.issue_valid && bus.u_fdiv && bus.l_fdiv) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_interlock_ctrl.sv
// Bench for interlock_ctrl: directed scenarios plus a randomized run, checked
// against a model that tracks the cycle at which each register and the
// divider become free again.
module tb_interlock_ctrl;

   localparam int LAT_W    = 4;
   localparam int FDIV_LAT = 12;
   localparam int CNT_W    = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic clk;
   logic rst;
   logic [CNT_W-1:0] stall_cnt;
   logic err;

   interlock_ctrl_if #(.LAT_W(LAT_W)) bus ();

   interlock_ctrl #(
      .NREG(32), .LAT_W(LAT_W), .FDIV_LAT(FDIV_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt), .err(err)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   // reference model: absolute cycle at which each resource is free again
   int cyc = 0;
   int ready_at [32];
   int div_ready = 0;
   int m_stall = 0;
   bit m_err = 0;
   bit exp_il, exp_iss;

   logic [6:0] exp_q [$];

   function automatic bit r_busy(input logic [4:0] r);
      return ready_at[r] > cyc;
   endfunction

   // wait until mid-cycle, then derive what the pair on the bus should do
   task automatic settle();
      bit haz;
      @(negedge clk);
      haz = 0;
      if (bus.u_src_use[0] && r_busy(bus.u_ra)) haz = 1;
      if (bus.u_src_use[1] && r_busy(bus.u_rb)) haz = 1;
      if (bus.u_src_use[2] && r_busy(bus.u_rs)) haz = 1;
      if (bus.l_src_use[0] && r_busy(bus.l_ra)) haz = 1;
      if (bus.l_src_use[1] && r_busy(bus.l_rb)) haz = 1;
      if (bus.l_src_use[2] && r_busy(bus.l_rs)) haz = 1;
      if (bus.u_dst_we && r_busy(bus.u_dst)) haz = 1;
      if (bus.l_dst_we && r_busy(bus.l_dst)) haz = 1;
      if ((bus.u_fdiv || bus.l_fdiv) && div_ready > cyc) haz = 1;
      exp_il  = bus.issue_valid && !bus.flush && haz;
      exp_iss = bus.issue_valid && !bus.flush && !haz;
   endtask

   // advance the model across the clock edge
   task automatic tick();
      if (rst) begin
         for (int i = 0; i < 32; i++) ready_at[i] = 0;
         div_ready = 0;
         m_stall = 0;
         m_err = 0;
      end else begin
         if (exp_il && m_stall < CNT_MAX) m_stall++;
         if (bus.issue_valid && bus.u_fdiv && bus.l_fdiv) m_err = 1;
         if (exp_iss) begin
            if (bus.u_dst_we && bus.u_lat != 0) ready_at[bus.u_dst] = cyc + int'(bus.u_lat) + 1;
            if (bus.l_dst_we && bus.l_lat != 0) ready_at[bus.l_dst] = cyc + int'(bus.l_lat) + 1;
            if (bus.u_fdiv || bus.l_fdiv) div_ready = cyc + FDIV_LAT + 1;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // driver tasks
   task automatic set_idle();
      bus.issue_valid = 0; bus.flush = 0;
      bus.u_src_use = 0; bus.u_ra = 0; bus.u_rb = 0; bus.u_rs = 0;
      bus.u_dst_we = 0; bus.u_dst = 0; bus.u_lat = 0; bus.u_fdiv = 0;
      bus.l_src_use = 0; bus.l_ra = 0; bus.l_rb = 0; bus.l_rs = 0;
      bus.l_dst_we = 0; bus.l_dst = 0; bus.l_lat = 0; bus.l_fdiv = 0;
   endtask

   task automatic drive_u(input logic [2:0] src, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] rs, input logic we, input logic [4:0] dst,
                          input logic [LAT_W-1:0] lat, input logic fdiv);
      bus.u_src_use = src; bus.u_ra = ra; bus.u_rb = rb; bus.u_rs = rs;
      bus.u_dst_we = we; bus.u_dst = dst; bus.u_lat = lat; bus.u_fdiv = fdiv;
   endtask

   task automatic drive_l(input logic [2:0] src, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] rs, input logic we, input logic [4:0] dst,
                          input logic [LAT_W-1:0] lat, input logic fdiv);
      bus.l_src_use = src; bus.l_ra = ra; bus.l_rb = rb; bus.l_rs = rs;
      bus.l_dst_we = we; bus.l_dst = dst; bus.l_lat = lat; bus.l_fdiv = fdiv;
   endtask

   task automatic do_reset();
      rst = 1;
      set_idle();
      repeat (2) begin
         @(negedge clk);
         exp_il = 0;
         exp_iss = 0;
         tick();
      end
      rst = 0;
   endtask

   task automatic idle_cycles(input int n);
      set_idle();
      repeat (n) begin
         settle();
         tick();
      end
   endtask

   // issue whatever pair is on the bus in one cycle
   task automatic issue_now(input string name);
      bus.issue_valid = 1;
      settle();
      total++;
      if (bus.issue !== 1'b1 || bus.interlock !== 1'b0)
         begin $display("FAIL %s: issue=%b interlock=%b want 1/0", name, bus.issue, bus.interlock); bad++; end
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      settle();
      total++;
      if (bus.interlock !== 1'b0 || bus.issue !== 1'b0)
         begin $display("FAIL reset_outputs: interlock=%b issue=%b want 0/0", bus.interlock, bus.issue); bad++; end
      total++;
      if (stall_cnt !== '0) begin $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); bad++; end
      total++;
      if (err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", err); bad++; end
      tick();
      drive_u(3'b111, 1, 2, 3, 1, 4, 3, 1);
      drive_l(3'b111, 5, 6, 7, 1, 8, 2, 0);
      issue_now("reset_first_issue");
      set_idle();
   endtask

   task automatic test_load_use();
      int stalls; bit done;
      do_reset();
      drive_u(3'b000, 0, 0, 0, 1, 5, 2, 0);
      issue_now("lu_producer");
      set_idle();
      drive_l(3'b001, 5, 0, 0, 0, 0, 0, 0);
      bus.issue_valid = 1;
      stalls = 0; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         settle();
         total++;
         if (bus.interlock !== exp_il)
            begin $display("FAIL lu_interlock: got %b want %b", bus.interlock, exp_il); bad++; end
         if (bus.issue === 1'b1) begin
            done = 1;
            total++;
            if (stall_cnt !== 2) begin $display("FAIL lu_stall_cnt: got %0d want 2", stall_cnt); bad++; end
         end else if (bus.interlock === 1'b1) stalls++;
         tick();
      end
      total++;
      if (!done || stalls != 2) begin $display("FAIL lu_stalls: got %0d done=%0d want 2", stalls, done); bad++; end
      set_idle();
   endtask

   task automatic test_divider();
      int stalls; bit done;
      do_reset();
      drive_u(3'b000, 0, 0, 0, 0, 0, 0, 1);
      issue_now("div_first");
      set_idle();
      drive_l(3'b000, 0, 0, 0, 0, 0, 0, 1);
      bus.issue_valid = 1;
      stalls = 0; done = 0;
      for (int k = 0; k < 30 && !done; k++) begin
         settle();
         total++;
         if (bus.interlock !== exp_il)
            begin $display("FAIL div_interlock: got %b want %b", bus.interlock, exp_il); bad++; end
         if (bus.issue === 1'b1) done = 1;
         else if (bus.interlock === 1'b1) stalls++;
         tick();
      end
      total++;
      if (!done || stalls != FDIV_LAT)
         begin $display("FAIL div_stalls: got %0d done=%0d want %0d", stalls, done, FDIV_LAT); bad++; end
      total++;
      if (stall_cnt !== FDIV_LAT) begin $display("FAIL div_stall_cnt: got %0d want %0d", stall_cnt, FDIV_LAT); bad++; end
      set_idle();
   endtask

   task automatic test_flush();
      int stalls; bit done;
      do_reset();
      drive_u(3'b000, 0, 0, 0, 1, 7, 3, 0);
      issue_now("fl_producer");
      set_idle();
      drive_u(3'b010, 0, 7, 0, 0, 0, 0, 0);
      bus.issue_valid = 1;
      bus.flush = 1;
      settle();
      total++;
      if (bus.interlock !== 1'b0 || bus.issue !== 1'b0)
         begin $display("FAIL fl_priority: interlock=%b issue=%b want 0/0", bus.interlock, bus.issue); bad++; end
      tick();
      bus.flush = 0;
      stalls = 0; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         settle();
         total++;
         if (bus.interlock !== exp_il)
            begin $display("FAIL fl_interlock: got %b want %b", bus.interlock, exp_il); bad++; end
         if (bus.issue === 1'b1) done = 1;
         else if (bus.interlock === 1'b1) stalls++;
         tick();
      end
      total++;
      if (!done || stalls != 2) begin $display("FAIL fl_stalls: got %0d done=%0d want 2", stalls, done); bad++; end
      total++;
      if (stall_cnt !== 2) begin $display("FAIL fl_stall_cnt: got %0d want 2", stall_cnt); bad++; end
      set_idle();
   endtask

   task automatic test_same_dst();
      int stalls; bit done;
      do_reset();
      drive_u(3'b000, 0, 0, 0, 1, 9, 1, 0);
      drive_l(3'b000, 0, 0, 0, 1, 9, 4, 0);
      issue_now("sd_producer");
      set_idle();
      drive_u(3'b010, 0, 9, 0, 0, 0, 0, 0);
      bus.issue_valid = 1;
      stalls = 0; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         settle();
         total++;
         if (bus.interlock !== exp_il)
            begin $display("FAIL sd_interlock: got %b want %b", bus.interlock, exp_il); bad++; end
         if (bus.issue === 1'b1) done = 1;
         else if (bus.interlock === 1'b1) stalls++;
         tick();
      end
      total++;
      if (!done || stalls != 4) begin $display("FAIL sd_stalls: got %0d done=%0d want 4", stalls, done); bad++; end
      set_idle();
      drive_u(3'b000, 0, 0, 0, 1, 10, 0, 0);
      issue_now("sd_lat0_producer");
      set_idle();
      drive_l(3'b100, 0, 0, 10, 0, 0, 0, 0);
      issue_now("sd_lat0_reader");
      set_idle();
   endtask

   task automatic test_reset_mid_err();
      do_reset();
      drive_u(3'b000, 0, 0, 0, 0, 0, 0, 1);
      issue_now("rm_fdiv");
      idle_cycles(5);
      drive_u(3'b000, 0, 0, 0, 1, 3, 4, 0);
      issue_now("rm_producer");
      set_idle();
      rst = 1;
      settle();
      tick();
      rst = 0;
      drive_u(3'b001, 3, 0, 0, 0, 0, 0, 1);
      issue_now("rm_after_reset");
      set_idle();
      drive_u(3'b000, 0, 0, 0, 0, 0, 0, 1);
      drive_l(3'b000, 0, 0, 0, 0, 0, 0, 1);
      bus.issue_valid = 1;
      settle();
      total++;
      if (err !== 1'b0) begin $display("FAIL err_before: got %b want 0", err); bad++; end
      tick();
      idle_cycles(3);
      total++;
      if (err !== 1'b1) begin $display("FAIL err_sticky: got %b want 1", err); bad++; end
      do_reset();
      settle();
      total++;
      if (err !== 1'b0) begin $display("FAIL err_cleared: got %b want 0", err); bad++; end
      tick();
   endtask

   task automatic test_waw_saturate();
      int stalls; bit done;
      do_reset();
      drive_u(3'b000, 0, 0, 0, 1, 2, 2, 0);
      issue_now("waw_producer");
      set_idle();
      drive_l(3'b000, 0, 0, 0, 1, 2, 1, 0);
      bus.issue_valid = 1;
      stalls = 0; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         settle();
         total++;
         if (bus.interlock !== exp_il)
            begin $display("FAIL waw_interlock: got %b want %b", bus.interlock, exp_il); bad++; end
         if (bus.issue === 1'b1) done = 1;
         else if (bus.interlock === 1'b1) stalls++;
         tick();
      end
      total++;
      if (!done || stalls != 2) begin $display("FAIL waw_stalls: got %0d done=%0d want 2", stalls, done); bad++; end
      set_idle();
      drive_u(3'b000, 0, 0, 0, 0, 0, 0, 1);
      issue_now("sat_fdiv");
      // two back-to-back Fdiv pairs stall 24 cycles in total
      for (int round = 0; round < 2; round++) begin
         drive_u(3'b000, 0, 0, 0, 0, 0, 0, 1);
         bus.issue_valid = 1;
         done = 0;
         for (int k = 0; k < 30 && !done; k++) begin
            settle();
            total++;
            if (stall_cnt !== CNT_W'(m_stall))
               begin $display("FAIL sat_track: got %0d want %0d", stall_cnt, m_stall); bad++; end
            if (bus.issue === 1'b1) done = 1;
            tick();
         end
         total++;
         if (!done) begin $display("FAIL sat_issue: round %0d never issued", round); bad++; end
      end
      set_idle();
      settle();
      total++;
      if (stall_cnt !== CNT_W'(CNT_MAX)) begin $display("FAIL sat_hold: got %0d want %0d", stall_cnt, CNT_MAX); bad++; end
      tick();
   endtask

   task automatic test_random();
      bit held;
      logic [6:0] got, want;
      do_reset();
      held = 0;
      for (int n = 0; n < 400; n++) begin
         if (!held) begin
            drive_u(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    LAT_W'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0));
            drive_l(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    LAT_W'($urandom_range(0, 5)), ($urandom_range(0, 15) == 0));
            bus.issue_valid = ($urandom_range(0, 3) != 0);
         end
         bus.flush = ($urandom_range(0, 7) == 0);
         settle();
         exp_q.push_back({exp_il, exp_iss, m_err, CNT_W'(m_stall)});
         got = {bus.interlock, bus.issue, err, stall_cnt};
         want = exp_q.pop_front();
         total++;
         if (got !== want)
            begin $display("FAIL rand_cycle%0d: got il/iss/err/cnt=%b want %b", n, got, want); bad++; end
         held = exp_il;
         tick();
      end
      set_idle();
   endtask

   initial begin
      rst = 1;
      set_idle();
      test_reset();
      test_load_use();
      test_divider();
      test_flush();
      test_same_dst();
      test_reset_mid_err();
      test_waw_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
